// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-ported memory shared by fetch (I) and mem stage (D).
// D-side wins ties; after STARVE_MAX straight D grants with I pending, I goes first.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   i_valid_i/i_addr_i/i_ready_o      fetch request handshake
//   i_resp_valid_o/i_rdata_o          fetch response pulse + data
//   d_valid_i/d_we_i/d_addr_i/d_wdata_i/d_ready_o   data request handshake
//   d_resp_valid_o/d_rdata_o          data response pulse + data (0 for writes)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_ack_i/mem_rdata_i  memory side
// Optional: define ARB_STATS_EN for stat_i_grants_o, stat_d_grants_o,
//   stat_conflicts_o (32b saturating counters).
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_valid_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ready_o,
  output logic              i_resp_valid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_valid_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ready_o,
  output logic              d_resp_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
`ifdef ARB_STATS_EN
  output logic [31:0]       stat_i_grants_o,
  output logic [31:0]       stat_d_grants_o,
  output logic [31:0]       stat_conflicts_o,
`endif
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t           state;
  logic             ownerD;
  logic [CNT_W-1:0] starveCnt;
  logic             starveFull;

  assign starveFull = (starveCnt == CNT_W'(STARVE_MAX));

  // Grants are combinational so a request is taken in the cycle it shows up.
  // Held low during reset so every output reads 0 while rst_i is high.
  always_comb begin
    d_ready_o = 1'b0;
    i_ready_o = 1'b0;
    if (state == IDLE && !rst_i) begin
      d_ready_o = d_valid_i & ~(i_valid_i & starveFull);
      i_ready_o = i_valid_i & ~d_ready_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ownerD         <= 1'b0;
      starveCnt      <= '0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      i_resp_valid_o <= 1'b0;
      i_rdata_o      <= '0;
      d_resp_valid_o <= 1'b0;
      d_rdata_o      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (d_ready_o) begin
            ownerD      <= 1'b1;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
            state       <= ISSUE;
            // Count D wins only while I is actually waiting.
            if (!i_valid_i)
              starveCnt <= '0;
            else if (!starveFull)
              starveCnt <= starveCnt + 1'b1;
          end else if (i_ready_o) begin
            ownerD      <= 1'b0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= i_addr_i;
            mem_wdata_o <= '0;
            state       <= ISSUE;
            starveCnt   <= '0;
          end
        end
        ISSUE: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= RESP;
            if (ownerD) begin
              d_resp_valid_o <= 1'b1;
              d_rdata_o      <= mem_we_o ? '0 : mem_rdata_i;
            end else begin
              i_resp_valid_o <= 1'b1;
              i_rdata_o      <= mem_rdata_i;
            end
          end
        end
        RESP: begin
          i_resp_valid_o <= 1'b0;
          d_resp_valid_o <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic conflict;
  assign conflict = (state == IDLE) & i_valid_i & d_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_i_grants_o  <= '0;
      stat_d_grants_o  <= '0;
      stat_conflicts_o <= '0;
    end else begin
      if (i_ready_o && stat_i_grants_o != '1)
        stat_i_grants_o <= stat_i_grants_o + 1'b1;
      if (d_ready_o && stat_d_grants_o != '1)
        stat_d_grants_o <= stat_d_grants_o + 1'b1;
      if (conflict && stat_conflicts_o != '1)
        stat_conflicts_o <= stat_conflicts_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter.
// Drives and samples on the falling edge; memory ack is driven by hand.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        iValid;
  logic [63:0] iAddr;
  logic        iReady;
  logic        iResp;
  logic [63:0] iRdata;
  logic        dValid;
  logic        dWe;
  logic [63:0] dAddr;
  logic [63:0] dWdata;
  logic        dReady;
  logic        dResp;
  logic [63:0] dRdata;
  logic        memReq;
  logic        memWe;
  logic [63:0] memAddr;
  logic [63:0] memWdata;
  logic        memAck;
  logic [63:0] memRdata;
`ifdef ARB_STATS_EN
  logic [31:0] statI;
  logic [31:0] statD;
  logic [31:0] statC;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(64),
    .DATA_W(64),
    .STARVE_MAX(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .i_valid_i(iValid),
    .i_addr_i(iAddr),
    .i_ready_o(iReady),
    .i_resp_valid_o(iResp),
    .i_rdata_o(iRdata),
    .d_valid_i(dValid),
    .d_we_i(dWe),
    .d_addr_i(dAddr),
    .d_wdata_i(dWdata),
    .d_ready_o(dReady),
    .d_resp_valid_o(dResp),
    .d_rdata_o(dRdata),
    .mem_req_o(memReq),
    .mem_we_o(memWe),
    .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata),
    .mem_ack_i(memAck),
`ifdef ARB_STATS_EN
    .stat_i_grants_o(statI),
    .stat_d_grants_o(statD),
    .stat_conflicts_o(statC),
`endif
    .mem_rdata_i(memRdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at an IDLE falling edge with valids already driven.
  // Returns at the IDLE falling edge after the response pulse.
  task automatic grant(input bit expD, input int delay,
                       input logic [63:0] rd, input logic [63:0] expAddr,
                       input bit expWe, input logic [63:0] expWdata,
                       input string tag);
    logic [63:0] expRd;
    expRd = (expD && expWe) ? 64'h0 : rd;
    #1;
    chk({tag, ".dReady"}, {63'h0, dReady}, {63'h0, expD});
    chk({tag, ".iReady"}, {63'h0, iReady}, {63'h0, !expD});
    tick();
    chk({tag, ".req"}, {63'h0, memReq}, 64'h1);
    chk({tag, ".addr"}, memAddr, expAddr);
    chk({tag, ".we"}, {63'h0, memWe}, {63'h0, expWe});
    chk({tag, ".wdata"}, memWdata, expWdata);
    chk({tag, ".busyRdy"}, {62'h0, iReady, dReady}, 64'h0);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk({tag, ".holdReq"}, {63'h0, memReq}, 64'h1);
      chk({tag, ".holdAddr"}, memAddr, expAddr);
      chk({tag, ".holdRdy"}, {62'h0, iReady, dReady}, 64'h0);
    end
    memAck = 1'b1;
    memRdata = rd;
    tick();
    memAck = 1'b0;
    memRdata = 64'h0;
    chk({tag, ".respI"}, {63'h0, iResp}, {63'h0, !expD});
    chk({tag, ".respD"}, {63'h0, dResp}, {63'h0, expD});
    chk({tag, ".rdata"}, expD ? dRdata : iRdata, expRd);
    chk({tag, ".reqDone"}, {63'h0, memReq}, 64'h0);
    chk({tag, ".respRdy"}, {62'h0, iReady, dReady}, 64'h0);
    tick();
    chk({tag, ".pulseEnd"}, {62'h0, iResp, dResp}, 64'h0);
  endtask

  initial begin
    logic [5:0] order;
    rst = 1'b1;
    iValid = 1'b1;
    dValid = 1'b1;
    iAddr = 64'h0;
    dWe = 1'b0;
    dAddr = 64'h0;
    dWdata = 64'h0;
    memAck = 1'b0;
    memRdata = 64'h0;
    #1;
    chk("rst.rdy", {62'h0, iReady, dReady}, 64'h0);
    chk("rst.req", {63'h0, memReq}, 64'h0);
    chk("rst.resp", {62'h0, iResp, dResp}, 64'h0);
    chk("rst.addr", memAddr, 64'h0);
    chk("rst.rdata", iRdata | dRdata, 64'h0);
    repeat (2) tick();
    iValid = 1'b0;
    dValid = 1'b0;
    rst = 1'b0;
    tick();

    // I-only read, minimum latency.
    iValid = 1'b1;
    iAddr = 64'h100;
    grant(1'b0, 0, 64'h30F3, 64'h100, 1'b0, 64'h0, "t1");
    iValid = 1'b0;
    chk("t1.hold", iRdata, 64'h30F3);

    // Both valid: D write wins, then I.
    dValid = 1'b1;
    dWe = 1'b1;
    dAddr = 64'h200;
    dWdata = 64'hAB;
    iValid = 1'b1;
    iAddr = 64'h104;
    grant(1'b1, 0, 64'hDEAD, 64'h200, 1'b1, 64'hAB, "t2d");
    dValid = 1'b0;
    dWe = 1'b0;
    grant(1'b0, 0, 64'h1111, 64'h104, 1'b0, 64'h0, "t2i");
    iValid = 1'b0;

    // Starvation guard: D,D,D,D,I,D.
    order = 6'b101111;
    dValid = 1'b1;
    dAddr = 64'h280;
    dWdata = 64'h0;
    iValid = 1'b1;
    iAddr = 64'h108;
    for (int k = 0; k < 6; k++)
      grant(order[k], 0, 64'h5000 + 64'(k),
            order[k] ? 64'h280 : 64'h108, 1'b0, 64'h0, "t3");
    dValid = 1'b0;

    // Slow memory, I pending throughout.
    dValid = 1'b1;
    dAddr = 64'h300;
    iAddr = 64'h10C;
    grant(1'b1, 4, 64'h4444, 64'h300, 1'b0, 64'h0, "t4d");
    dValid = 1'b0;
    grant(1'b0, 0, 64'h4545, 64'h10C, 1'b0, 64'h0, "t4i");
    iValid = 1'b0;

    // Reset during ISSUE, late ack ignored.
    iValid = 1'b1;
    iAddr = 64'h500;
    #1;
    chk("t5.iRdy", {63'h0, iReady}, 64'h1);
    tick();
    iValid = 1'b0;
    chk("t5.req", {63'h0, memReq}, 64'h1);
    rst = 1'b1;
    #1;
    chk("t5.rstReq", {63'h0, memReq}, 64'h0);
    chk("t5.rstAddr", memAddr, 64'h0);
    tick();
    rst = 1'b0;
    memAck = 1'b1;
    memRdata = 64'h99;
    tick();
    memAck = 1'b0;
    chk("t5.noResp", {62'h0, iResp, dResp}, 64'h0);
    chk("t5.noReq", {63'h0, memReq}, 64'h0);
    tick();
    chk("t5.noResp2", {62'h0, iResp, dResp}, 64'h0);
    dValid = 1'b1;
    dAddr = 64'h600;
    grant(1'b1, 0, 64'h77, 64'h600, 1'b0, 64'h0, "t5d");
    dValid = 1'b0;

    // Stats scenario: 3 conflicts, 3 D grants, 2 I grants.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    dValid = 1'b1;
    iValid = 1'b1;
    dAddr = 64'h700;
    iAddr = 64'h180;
    for (int k = 0; k < 3; k++)
      grant(1'b1, 0, 64'h7000, 64'h700, 1'b0, 64'h0, "t6d");
    dValid = 1'b0;
    for (int k = 0; k < 2; k++)
      grant(1'b0, 0, 64'h1800, 64'h180, 1'b0, 64'h0, "t6i");
    iValid = 1'b0;
`ifdef ARB_STATS_EN
    chk("t6.statC", {32'h0, statC}, 64'd3);
    chk("t6.statI", {32'h0, statI}, 64'd2);
    chk("t6.statD", {32'h0, statD}, 64'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
